// File: rtl/vga_pkg.sv
// Shared constants for the 160x120 VGA adapter and the puzzle's drawing engines.
package vga_pkg;

  // Visible screen size in pixels
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;

  // Coordinate and colour widths used on the adapter's write port
  localparam int VGA_X_W      = 8;
  localparam int VGA_Y_W      = 7;
  localparam int VGA_COLOUR_W = 3;

  // Engine indices on the arbiter's request vector
  localparam int ENG_CLEAR  = 0;
  localparam int ENG_GRID   = 1;
  localparam int ENG_BANNER = 2;
  localparam int ENG_NUM    = 3;

endpackage

// File: rtl/vram_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// rr_ptr, searching upward with wrap-around, plus a valid flag.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] win,
  output logic                    valid
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand_s [NREQ];

  // Candidate search order: rr_ptr, rr_ptr+1, ... modulo NREQ
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cand_s[i] = IDX_W'((int'(rr_ptr) + i) % NREQ);
    end
  end

  // The first requesting candidate in search order wins
  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[cand_s[i]]) begin
        win   = cand_s[i];
        valid = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Single-writer arbiter for the VGA adapter write port. Engines hold the port
// for a whole burst; release is by a last-tagged plot, by dropping req, or by
// the watchdog when the owner stops plotting.
module vram_write_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int X_W      = VGA_X_W,
  parameter int Y_W      = VGA_Y_W,
  parameter int COLOUR_W = VGA_COLOUR_W,
  parameter int TIMEOUT  = 1023
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          plot,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*X_W-1:0]      x_in,
  input  logic [NREQ*Y_W-1:0]      y_in,
  input  logic [NREQ*COLOUR_W-1:0] colour_in,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COLOUR_W-1:0]      vga_colour,
  output logic                     vga_plot,
  output logic                     timeout_err
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  // Registered state
  logic [0:0]          state_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [WD_W-1:0]     wd_r;
  logic [NREQ-1:0]     grant_r;
  logic [IDX_W-1:0]    owner_r;
  logic                busy_r;
  logic [X_W-1:0]      vga_x_r;
  logic [Y_W-1:0]      vga_y_r;
  logic [COLOUR_W-1:0] vga_colour_r;
  logic                vga_plot_r;
  logic                timeout_err_r;

  // Next-state and selection signals
  logic [0:0]          state_nxt_s;
  logic [IDX_W-1:0]    rr_ptr_nxt_s;
  logic [WD_W-1:0]     wd_nxt_s;
  logic [NREQ-1:0]     grant_nxt_s;
  logic [IDX_W-1:0]    owner_nxt_s;
  logic                terr_nxt_s;
  logic                fwd_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_vld_s;
  logic                own_req_s;
  logic                own_plot_s;
  logic                own_last_s;
  logic [X_W-1:0]      own_x_s;
  logic [Y_W-1:0]      own_y_s;
  logic [COLOUR_W-1:0] own_colour_s;
  logic [WD_W-1:0]     wd_inc_s;
  logic                wd_hit_s;
  logic [IDX_W-1:0]    ptr_after_owner_s;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .win    (pick_idx_s),
    .valid  (pick_vld_s)
  );

  // Only the current owner's lanes are ever looked at
  assign own_req_s    = req[owner_r];
  assign own_plot_s   = plot[owner_r];
  assign own_last_s   = last[owner_r];
  assign own_x_s      = x_in[int'(owner_r)*X_W +: X_W];
  assign own_y_s      = y_in[int'(owner_r)*Y_W +: Y_W];
  assign own_colour_s = colour_in[int'(owner_r)*COLOUR_W +: COLOUR_W];

  // Saturating watchdog increment; the limit is reached when the next count hits TIMEOUT
  assign wd_inc_s = (wd_r >= WD_MAX) ? WD_MAX : (wd_r + WD_W'(1));
  assign wd_hit_s = (wd_inc_s >= WD_MAX);

  assign ptr_after_owner_s = IDX_W'((int'(owner_r) + 1) % NREQ);

  // Arbitration FSM, watchdog and release decisions
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    wd_nxt_s     = wd_r;
    grant_nxt_s  = grant_r;
    owner_nxt_s  = owner_r;
    terr_nxt_s   = 1'b0;
    fwd_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_nxt_s = '0;
        wd_nxt_s    = '0;
        if (pick_vld_s) begin
          state_nxt_s = ST_ACTIVE;
          grant_nxt_s = NREQ'(1) << pick_idx_s;
          owner_nxt_s = pick_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Any owner plot is forwarded, including one that coincides with release
        fwd_s = own_plot_s;
        if (own_plot_s) begin
          wd_nxt_s = '0;
        end else begin
          wd_nxt_s = wd_inc_s;
        end
        if ((own_plot_s && own_last_s) || !own_req_s || (!own_plot_s && wd_hit_s)) begin
          state_nxt_s  = ST_IDLE;
          grant_nxt_s  = '0;
          wd_nxt_s     = '0;
          rr_ptr_nxt_s = ptr_after_owner_s;
          // Abandon and normal release win over the watchdog
          terr_nxt_s   = own_req_s && !own_plot_s && wd_hit_s;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = '0;
        wd_nxt_s    = '0;
      end
    endcase
  end

  // State, arbitration and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      wd_r          <= '0;
      grant_r       <= '0;
      owner_r       <= '0;
      busy_r        <= 1'b0;
      vga_x_r       <= '0;
      vga_y_r       <= '0;
      vga_colour_r  <= '0;
      vga_plot_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      wd_r          <= wd_nxt_s;
      grant_r       <= grant_nxt_s;
      owner_r       <= owner_nxt_s;
      busy_r        <= |grant_nxt_s;
      vga_plot_r    <= fwd_s;
      timeout_err_r <= terr_nxt_s;
      if (fwd_s) begin
        vga_x_r      <= own_x_s;
        vga_y_r      <= own_y_s;
        vga_colour_r <= own_colour_s;
      end else begin
        vga_x_r      <= vga_x_r;
        vga_y_r      <= vga_y_r;
        vga_colour_r <= vga_colour_r;
      end
    end
  end

  assign grant       = grant_r;
  assign owner       = owner_r;
  assign busy        = busy_r;
  assign vga_x       = vga_x_r;
  assign vga_y       = vga_y_r;
  assign vga_colour  = vga_colour_r;
  assign vga_plot    = vga_plot_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: engines are modelled as bursty
// writers, a behavioural model predicts every grant change, forwarded plot and
// watchdog pulse with its cycle, and a monitor pops and compares them.
module tb_vram_write_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, plot, last;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        timeout_err;

  vram_write_arbiter #(
    .NREQ(NREQ), .X_W(8), .Y_W(7), .COLOUR_W(3), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .plot(plot), .last(last),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .grant(grant), .owner(owner), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; } pev_t;
  typedef struct { int cyc; logic [3:0] g; int o; } gev_t;

  pev_t pq[$];
  gev_t gq[$];
  int   tq[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference model: owner index (-1 when idle), pointer, cycles without a plot
  int m_owner = -1;
  int m_ptr   = 0;
  int m_quiet = 0;

  // Engine behaviour
  bit want [4];
  int rem [4];
  int stall [4];
  int stall_on_plot [4];
  bit drop_next [4];
  bit rand_mode = 1'b0;
  bit garbage   = 1'b0;
  bit inject3   = 1'b0;
  int rereq0    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_vga_x"}, 32'(vga_x), 32'd0);
    chk({tag, "_vga_y"}, 32'(vga_y), 32'd0);
    chk({tag, "_vga_colour"}, 32'(vga_colour), 32'd0);
    chk({tag, "_vga_plot"}, 32'(vga_plot), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Predict what the DUT shows after the coming clock edge
  task automatic model();
    int  o;
    int  e;
    bit  rel;
    bit  to;
    bit  found;
    if (!resetn) begin
      if (m_owner >= 0) gq.push_back(gev_t'{cyc + 1, 4'b0000, 0});
      m_owner = -1;
      m_ptr   = 0;
      m_quiet = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        e = (m_ptr + k) % NREQ;
        if (!found && req[e]) begin
          found   = 1'b1;
          m_owner = e;
          m_quiet = 0;
          gq.push_back(gev_t'{cyc + 1, 4'(1 << e), e});
        end
      end
    end else begin
      o   = m_owner;
      rel = 1'b0;
      to  = 1'b0;
      if (plot[o]) begin
        pq.push_back(pev_t'{cyc + 1, x_in[o*8 +: 8], y_in[o*7 +: 7], colour_in[o*3 +: 3]});
        m_quiet = 0;
        if (last[o]) rel = 1'b1;
      end else begin
        m_quiet++;
      end
      if (!req[o]) rel = 1'b1;
      else if (!plot[o] && m_quiet >= TMO) begin
        rel = 1'b1;
        to  = 1'b1;
      end
      if (rel) begin
        m_owner = -1;
        m_ptr   = (o + 1) % NREQ;
        gq.push_back(gev_t'{cyc + 1, 4'b0000, o});
        if (to) tq.push_back(cyc + 1);
      end
    end
  endtask

  // Drive one cycle of engine activity, update the model, advance to next negedge
  task automatic step();
    for (int e = 0; e < NREQ; e++) begin
      plot[e] = 1'b0;
      last[e] = 1'b0;
      x_in[e*8 +: 8]      = 8'($urandom_range(0, 159));
      y_in[e*7 +: 7]      = 7'($urandom_range(0, 119));
      colour_in[e*3 +: 3] = 3'($urandom_range(0, 7));
      if (drop_next[e]) begin
        want[e]      = 1'b0;
        drop_next[e] = 1'b0;
      end else if (!want[e] && rand_mode && $urandom_range(0, 3) == 0) begin
        want[e] = 1'b1;
        rem[e]  = int'($urandom_range(1, 4));
      end
      if (want[e] && m_owner == e) begin
        if (stall[e] > 0) stall[e]--;
        else if (rand_mode && $urandom_range(0, 39) == 0) want[e] = 1'b0;
        else if (rand_mode && $urandom_range(0, 7) == 0) stall[e] = int'($urandom_range(0, 10));
        else begin
          plot[e] = 1'b1;
          rem[e]--;
          if (rem[e] <= 0) begin
            last[e] = 1'b1;
            if (e == 0 && rereq0 > 0) begin
              rereq0--;
              rem[0] = 2;
            end else if ($urandom_range(0, 1) == 0) want[e] = 1'b0;
            else drop_next[e] = 1'b1;
          end else if (stall_on_plot[e] > 0) begin
            stall[e] = stall_on_plot[e];
            stall_on_plot[e] = 0;
          end
        end
      end else if (garbage && $urandom_range(0, 15) == 0) begin
        plot[e] = 1'b1;
        last[e] = 1'($urandom_range(0, 1));
      end
      req[e] = want[e];
    end
    if (inject3 && m_owner == 1) begin
      plot[3]      = 1'b1;
      last[3]      = 1'b0;
      x_in[31:24]  = 8'd10;
      y_in[27:21]  = 7'd20;
    end
    model();
    @(negedge clk);
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while ((m_owner >= 0 || want[0] || want[1] || want[2] || want[3]) && k < maxc) begin
      step();
      k++;
    end
    chk({tag, "_idle_reached"}, 32'(m_owner < 0 && !(want[0] || want[1] || want[2] || want[3])), 32'd1);
  endtask

  // Monitor: pop expected events whenever the DUT presents them
  initial begin
    logic [3:0] prev_g;
    pev_t p;
    gev_t g;
    int   t;
    prev_g = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
          p = pq.pop_front();
          chk("plot_missing_at", 32'(cyc), 32'(p.cyc));
        end
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
          g = gq.pop_front();
          chk("grant_change_missing_at", 32'(cyc), 32'(g.cyc));
        end
        while (tq.size() > 0 && tq[0] < cyc) begin
          t = tq.pop_front();
          chk("timeout_missing_at", 32'(cyc), 32'(t));
        end
        if (vga_plot !== 1'b0) begin
          if (pq.size() == 0) chk("plot_unexpected", 32'(vga_plot), 32'd0);
          else begin
            p = pq.pop_front();
            chk("plot_cycle", 32'(cyc), 32'(p.cyc));
            chk("vga_x", 32'(vga_x), 32'(p.x));
            chk("vga_y", 32'(vga_y), 32'(p.y));
            chk("vga_colour", 32'(vga_colour), 32'(p.c));
          end
        end
        if (grant !== prev_g) begin
          if (gq.size() == 0) chk("grant_unexpected", 32'(grant), 32'(prev_g));
          else begin
            g = gq.pop_front();
            chk("grant_cycle", 32'(cyc), 32'(g.cyc));
            chk("grant", 32'(grant), 32'(g.g));
            chk("owner", 32'(owner), 32'(g.o));
            chk("busy", 32'(busy), 32'(g.g != 4'b0000));
          end
        end
        if (timeout_err !== 1'b0) begin
          if (tq.size() == 0) chk("timeout_unexpected", 32'(timeout_err), 32'd0);
          else begin
            t = tq.pop_front();
            chk("timeout_cycle", 32'(cyc), 32'(t));
          end
        end
      end
      prev_g = grant;
    end
  end

  initial begin
    resetn = 1'b0;
    req = 4'b0; plot = 4'b0; last = 4'b0;
    x_in = 32'd0; y_in = 28'd0; colour_in = 12'd0;
    for (int e = 0; e < NREQ; e++) begin
      want[e] = 1'b0; rem[e] = 0; stall[e] = 0; stall_on_plot[e] = 0; drop_next[e] = 1'b0;
    end
    repeat (3) step();
    check_all_zero("reset");
    mon_en = 1'b1;
    resetn = 1'b1;

    // Grid engine alone, 5-plot burst, with engine 3 plotting out of turn
    inject3 = 1'b1;
    want[1] = 1'b1; rem[1] = 5;
    run_idle("single", 60);
    inject3 = 1'b0;

    // All engines from reset, 2-plot bursts; engine 0 keeps re-requesting
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int e = 0; e < NREQ; e++) begin
      want[e] = 1'b1; rem[e] = 2;
    end
    rereq0 = 2;
    run_idle("contention", 200);

    // Engine 3 goes quiet after one plot while engine 0 waits
    want[3] = 1'b1; rem[3] = 3; stall_on_plot[3] = TMO + 2;
    step();
    step();
    want[0] = 1'b1; rem[0] = 2;
    run_idle("watchdog", 200);

    // Reset in the middle of engine 2's burst
    want[2] = 1'b1; rem[2] = 6;
    repeat (3) step();
    resetn = 1'b0;
    want[2] = 1'b0; drop_next[2] = 1'b0; stall[2] = 0;
    step();
    check_all_zero("mid_reset");
    resetn = 1'b1;
    want[1] = 1'b1; rem[1] = 2;
    want[3] = 1'b1; rem[3] = 2;
    run_idle("post_reset", 100);

    // Randomised traffic with stalls, abandons and out-of-turn plots
    rand_mode = 1'b1;
    garbage   = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    garbage   = 1'b0;
    run_idle("random", 2000);
    repeat (4) step();

    chk("plot_queue_drained", 32'(pq.size()), 32'd0);
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("timeout_queue_drained", 32'(tq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
